// File: rtl/score_display_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// score_display_ctrl
//
// Converts a binary score to NUM_DIGITS BCD digits using a sequential
// double-dabble engine that handles one bit per cycle. It drives registered,
// active-low seven-segment patterns with the decimal point off. The displayed
// outputs change in one step, on the LATCH edge, so the pins never show a
// partially converted value. A score above 10^NUM_DIGITS-1 saturates to all
// nines and raises overflow.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, every digit above the most significant non-zero digit is
//   blanked (8'hFF). Digit 0 always shows its value. digits_bcd is unaffected.
//
// Parameters
//   NUM_DIGITS  number of decimal digits, 1..8
//   SCORE_W     width of the binary score, 1..32
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   score_in     binary score, captured when a load is accepted
//   score_valid  load request, honoured only while busy=0
//   busy         conversion in progress (CONVERT or LATCH)
//   update_done  one-cycle pulse coinciding with new display values
//   overflow     last accepted score exceeded 10^NUM_DIGITS-1
//   digits_bcd   displayed BCD, digit 0 (ones) in [3:0]
//   seg_out      active-low {dp,g,f,e,d,c,b,a} per digit, digit i in [8i+7:8i]
// ---------------------------------------------------------------------------

// Single-digit BCD to active-low segment decoder. blank forces all segments off.
module seg_digit_dec (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] seg
);
    always_comb begin
        seg = 8'hFF;
        if (!blank) begin
            case (digit)
                4'd0:    seg = 8'hC0;
                4'd1:    seg = 8'hF9;
                4'd2:    seg = 8'hA4;
                4'd3:    seg = 8'hB0;
                4'd4:    seg = 8'h99;
                4'd5:    seg = 8'h92;
                4'd6:    seg = 8'h82;
                4'd7:    seg = 8'hF8;
                4'd8:    seg = 8'h80;
                4'd9:    seg = 8'h90;
                default: seg = 8'hFF;  // non-BCD codes cannot reach here
            endcase
        end
    end
endmodule

module score_display_ctrl #(
    parameter int NUM_DIGITS = 2,
    parameter int SCORE_W    = 7
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [SCORE_W-1:0]      score_in,
    input  logic                    score_valid,
    output logic                    busy,
    output logic                    update_done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] digits_bcd,
    output logic [8*NUM_DIGITS-1:0] seg_out
);

    // One spare nibble above the displayed digits, so inputs wider than the
    // display cannot corrupt the carry chain. Those inputs are saturated
    // anyway.
    localparam int BCD_W = NUM_DIGITS*4 + 4;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    // The reset display shows "0". With blanking, only digit 0 is lit.
    function automatic logic [8*NUM_DIGITS-1:0] seg_rst_val();
        logic [8*NUM_DIGITS-1:0] r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            r[8*i +: 8] = (i == 0) ? 8'hC0 : 8'hFF;
`else
            r[8*i +: 8] = 8'hC0;
`endif
        end
        return r;
    endfunction

    localparam logic [8*NUM_DIGITS-1:0] SEG_RST = seg_rst_val();

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_LATCH   = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [BCD_W-1:0]     bcd_acc;
    logic [BCD_W-1:0]     bcd_adj;
    logic [SCORE_W-1:0]   bin_sr;
    logic                 ovf_pend;

    logic                 load_en;
    logic                 shift_en;
    logic                 latch_en;

    logic [4*NUM_DIGITS-1:0] digits_nxt;
    logic [8*NUM_DIGITS-1:0] seg_nxt;
    logic [NUM_DIGITS-1:0]   blank;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (score_valid) state_nxt = S_CONVERT;
            // The counter is loaded with SCORE_W, so the edge that leaves
            // CONVERT performs the final shift.
            S_CONVERT: if (bit_cnt == CNT_W'(1)) state_nxt = S_LATCH;
            S_LATCH:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (state != S_IDLE);
        load_en  = (state == S_IDLE) && score_valid;
        shift_en = (state == S_CONVERT);
        latch_en = (state == S_LATCH);
    end

    // ---------------- double-dabble datapath ----------------
    // Before each shift, every nibble >= 5 gets +3. After the doubling, the
    // nibble then carries correctly into the next decade.
    always_comb begin
        bcd_adj = bcd_acc;
        for (int i = 0; i < BCD_W/4; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bcd_acc  <= '0;
            bin_sr   <= '0;
            bit_cnt  <= '0;
            ovf_pend <= 1'b0;
        end else if (load_en) begin
            bcd_acc  <= '0;
            bin_sr   <= score_in;
            bit_cnt  <= CNT_W'(SCORE_W);
            // The check is on the raw input. The BCD accumulator would
            // truncate it.
            ovf_pend <= (64'(score_in) > MAX_VAL);
        end else if (shift_en) begin
            {bcd_acc, bin_sr} <= {bcd_adj, bin_sr} << 1;
            bit_cnt           <= bit_cnt - CNT_W'(1);
        end
    end

    // ---------------- display value and segment decode ----------------
    assign digits_nxt = ovf_pend ? {NUM_DIGITS{4'h9}} : bcd_acc[4*NUM_DIGITS-1:0];

    // Scan from the top digit down. A digit is blanked while it and every
    // digit above it are zero. Digit 0 is never blanked.
    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic run_zero;
            run_zero = 1'b1;
            for (int i = NUM_DIGITS-1; i >= 1; i--) begin
                run_zero = run_zero && (digits_nxt[4*i +: 4] == 4'd0);
                blank[i] = run_zero;
            end
        end
`endif
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        seg_digit_dec u_dec (
            .digit (digits_nxt[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg_nxt[8*g +: 8])
        );
    end

    // Displayed outputs move only in LATCH. They hold steady through CONVERT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            update_done <= 1'b0;
            overflow    <= 1'b0;
            digits_bcd  <= '0;
            seg_out     <= SEG_RST;
        end else begin
            update_done <= latch_en;
            if (latch_en) begin
                overflow   <= ovf_pend;
                digits_bcd <= digits_nxt;
                seg_out    <= seg_nxt;
            end
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
`timescale 1ns/1ps
module tb_score_display_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // DUT A: 2 digits, 7-bit score
    logic [6:0]  score_in;
    logic        score_valid;
    logic        busy, update_done, overflow;
    logic [7:0]  digits_bcd;
    logic [15:0] seg_out;

    // DUT B: 4 digits, 14-bit score
    logic [13:0] score_b;
    logic        valid_b;
    logic        busy_b, done_b, ovf_b;
    logic [15:0] digits_b;
    logic [31:0] seg_b;

    score_display_ctrl #(.NUM_DIGITS(2), .SCORE_W(7)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .score_in(score_in), .score_valid(score_valid),
        .busy(busy), .update_done(update_done), .overflow(overflow),
        .digits_bcd(digits_bcd), .seg_out(seg_out));

    score_display_ctrl #(.NUM_DIGITS(4), .SCORE_W(14)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .score_in(score_b), .score_valid(valid_b),
        .busy(busy_b), .update_done(done_b), .overflow(ovf_b),
        .digits_bcd(digits_b), .seg_out(seg_b));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic longint p10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic longint sat(input longint v, input int nd);
        return (v > p10(nd) - 1) ? p10(nd) - 1 : v;
    endfunction

    function automatic logic [31:0] m_bcd(input longint v, input int nd);
        logic [31:0] r = '0;
        longint s = sat(v, nd);
        for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((s / p10(i)) % 10);
        return r;
    endfunction

    function automatic logic [63:0] m_seg(input longint v, input int nd);
        logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        logic [63:0] r = '0;
        longint s = sat(v, nd);
        for (int i = 0; i < nd; i++) begin
            logic [7:0] d;
            d = tbl[(s / p10(i)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && s < p10(i)) d = 8'hFF;
`endif
            r[8*i +: 8] = d;
        end
        return r;
    endfunction

    // Currently displayed value on DUT A, as the model expects it
    logic [7:0]  e_bcd;
    logic [15:0] e_seg;
    logic        e_ovf;

    task automatic model_reset();
        e_bcd = '0;
        e_seg = 16'(m_seg(0, 2));
        e_ovf = 1'b0;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_busy"},  busy,        0);
        chk({tag, "_done"},  update_done, 0);
        chk({tag, "_ovf"},   overflow,    0);
        chk({tag, "_bcd"},   digits_bcd,  0);
        chk({tag, "_seg"},   seg_out,     m_seg(0, 2));
        chk({tag, "_busyb"}, busy_b,      0);
        chk({tag, "_bcdb"},  digits_b,    0);
        chk({tag, "_segb"},  seg_b,       m_seg(0, 4));
    endtask

    // Load v into DUT A, starting and ending on a negedge.
    // junk: -1 = quiet, -2 = random requests while busy, >=0 = single pulse of that value.
    task automatic load_a(input int v, input int junk);
        score_in = 7'(v);
        score_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        for (int j = 0; j <= 9; j++) begin
            // j = number of edges since the accepting edge
            if (j < 8) begin
                chk("busy_hi",  busy,        1);
                chk("done_lo",  update_done, 0);
                chk("hold_bcd", digits_bcd,  e_bcd);
                chk("hold_seg", seg_out,     e_seg);
                chk("hold_ovf", overflow,    e_ovf);
            end else if (j == 8) begin
                e_bcd = 8'(m_bcd(v, 2));
                e_seg = 16'(m_seg(v, 2));
                e_ovf = (v > 99);
                chk("done_hi", update_done, 1);
                chk("busy_lo", busy,        0);
                chk("bcd",     digits_bcd,  e_bcd);
                chk("seg",     seg_out,     e_seg);
                chk("ovf",     overflow,    e_ovf);
            end else begin
                chk("done_once", update_done, 0);
                chk("idle",      busy,        0);
                chk("post_bcd",  digits_bcd,  e_bcd);
                chk("post_seg",  seg_out,     e_seg);
            end
            if (j < 8 && junk == -2) begin
                score_valid = 1'($urandom_range(0, 1));
                score_in    = 7'($urandom);
            end else if (j < 8 && junk >= 0) begin
                score_valid = (j == 2);
                score_in    = 7'(junk);
            end else begin
                score_valid = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    task automatic load_b(input int v);
        int j;
        score_b = 14'(v);
        valid_b = 1'b1;
        @(posedge clock);
        @(negedge clock);
        valid_b = 1'b0;
        j = 0;
        while (!done_b && j < 40) begin
            @(negedge clock);
            j++;
        end
        chk("b_latency", j,        15);
        chk("b_bcd",     digits_b, m_bcd(v, 4));
        chk("b_seg",     seg_b,    m_seg(v, 4));
        chk("b_ovf",     ovf_b,    (v > 9999));
        @(negedge clock);
        chk("b_done_once", done_b, 0);
    endtask

    initial begin
        score_in = '0; score_valid = 1'b0;
        score_b  = '0; valid_b     = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        chk_rst("rst");
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk_rst("idle");

        // directed cases
        load_a(42, -1);
        load_a(99, -1);
        load_a(127, -1);
        load_a(5, 63);
        load_a(0, -1);
        load_a(100, -2);
        load_a(9, -1);
        load_a(10, -1);

        // reset partway through a conversion
        score_in = 7'd88;
        score_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        score_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_rst("async");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        load_a(3, -1);

        // randomized loads with random gaps and ignored requests
        for (int n = 0; n < 40; n++) begin
            load_a(int'($urandom_range(0, 127)), ($urandom_range(0, 1) == 1) ? -2 : -1);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        // wide configuration
        load_b(9999);
        load_b(16383);
        load_b(1000);
        load_b(7);
        load_b(int'($urandom_range(0, 16383)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
